// File: rtl/hazard_pkg.sv
// Shared types and statistics-select group bases for the hazard scheduler.
package hazard_pkg;

  localparam int PC_W_DEF = 32;
  typedef logic [PC_W_DEF-1:0] pc_t;

  // stat_sel group index; the select base for a group is group * NUM_STAGES
  localparam int STAT_STALL_CYC = 0;
  localparam int STAT_STALL_EP  = 1;
  localparam int STAT_REDIR     = 2;

endpackage

// File: rtl/hazard_stat_counter.sv
// Saturating event counter; clear wins over increment.
module hazard_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/flush/redirect resolution for an S-stage in-order pipeline, plus deadlock watchdog.
// Optional per-stage hazard statistics when HAZARD_STATS_EN is defined.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int  NUM_STAGES = 5,
  parameter int  PC_W       = 32,
  parameter int  WDOG_LIMIT = 1024,
  parameter int  CNT_W      = 32,
  localparam int SEL_W      = $clog2(3 * NUM_STAGES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_STAGES-1:0]      stall_req,
  input  logic [NUM_STAGES-1:0]      redirect_req,
  input  logic [NUM_STAGES-1:0]      redirect_keep_slot,
  input  logic [NUM_STAGES*PC_W-1:0] redirect_target,
  output logic [NUM_STAGES-1:0]      redirect_ack,
  output logic [NUM_STAGES-1:0]      stall_o,
  output logic [NUM_STAGES-1:0]      flush_o,
  output logic                       pc_we,
  output logic [PC_W-1:0]            pc_new,
  output logic                       hang,
  input  logic [SEL_W-1:0]           stat_sel,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           stat_data
);

  localparam int WDOG_W = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);

  int               w, h;
  logic             have_w, have_h, blocked, keep;
  logic [PC_W-1:0]  tgt;

  always_comb begin
    stall_o      = '0;
    flush_o      = '0;
    pc_we        = 1'b0;
    pc_new       = '0;
    redirect_ack = '0;
    w = 0; h = 0; have_w = 1'b0; have_h = 1'b0; blocked = 1'b0; keep = 1'b0; tgt = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (redirect_req[i]) begin
        have_w = 1'b1;
        w      = i;
        keep   = redirect_keep_slot[i];
        tgt    = redirect_target[i*PC_W +: PC_W];
      end
      if (stall_req[i]) begin
        have_h = 1'b1;
        h      = i;
      end
    end
    // the oldest redirect waits while it or anything older is stalled
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i >= w && stall_req[i]) blocked = 1'b1;
    end
    if (rst) begin
      flush_o = '1;
    end else if (have_w && !blocked) begin
      pc_we  = 1'b1;
      pc_new = tgt;
      for (int j = 0; j < NUM_STAGES; j++) begin
        redirect_ack[j] = (j == w);
        if (j >= 1 && (j < w || (j == w && !keep))) flush_o[j] = 1'b1;
      end
    end else if (have_h) begin
      for (int j = 0; j < NUM_STAGES; j++) begin
        if (j <= h) stall_o[j] = 1'b1;
        else if (j == h + 1) flush_o[j] = 1'b1;
      end
    end
  end

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              hang_q, hang_d;

  always_comb begin
    wdog_d = '0;
    hang_d = hang_q;
    if (stall_o[0] && !pc_we) begin
      wdog_d = (wdog_q == WDOG_W'(WDOG_LIMIT)) ? wdog_q : wdog_q + 1'b1;
    end
    if (WDOG_LIMIT != 0 && wdog_d == WDOG_W'(WDOG_LIMIT)) hang_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      hang_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      hang_q <= hang_d;
    end
  end

  assign hang = hang_q;

`ifdef HAZARD_STATS_EN
  logic [NUM_STAGES-1:0] prev_q;
  logic [CNT_W-1:0]      cnt [3*NUM_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= stall_req;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stat
    hazard_stat_counter #(.CNT_W(CNT_W)) u_cyc (
      .clk(clk), .rst(rst), .inc_i(stall_req[g]), .clr_i(stat_clr),
      .cnt_o(cnt[STAT_STALL_CYC*NUM_STAGES+g]));
    hazard_stat_counter #(.CNT_W(CNT_W)) u_ep (
      .clk(clk), .rst(rst), .inc_i(stall_req[g] & ~prev_q[g]), .clr_i(stat_clr),
      .cnt_o(cnt[STAT_STALL_EP*NUM_STAGES+g]));
    hazard_stat_counter #(.CNT_W(CNT_W)) u_rd (
      .clk(clk), .rst(rst), .inc_i(redirect_ack[g]), .clr_i(stat_clr),
      .cnt_o(cnt[STAT_REDIR*NUM_STAGES+g]));
  end

  always_comb begin
    stat_data = '0;
    for (int i = 0; i < 3*NUM_STAGES; i++) begin
      if (int'(stat_sel) == i) stat_data = cnt[i];
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_data   = '0;
`endif

endmodule
